theta_slice_stage: RTL and testbench

- Slice-serial Keccak theta step on a 1600-bit state held as 64 slices of 25 bits.
- Sits directly upstream of permutation_func. Reads slices from a combinational-read slice memory and emits theta-mixed slices as a write_enable/write_value stream, which is written into the memory that permutation_func then reads.
- Uses two passes over the memory. Pass 1 accumulates the column parities; pass 2 re-reads each slice and XORs in the theta column effect. No full state buffer is needed.

---
 rtl/keccak_slice_pkg.sv | 21 ++
 rtl/theta_slice_stage_if.sv | 14 +
 rtl/theta_column_mix.sv | 15 +
 rtl/theta_slice_stage.sv | 68 ++++++
 tb/tb_theta_slice_stage.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/keccak_slice_pkg.sv
// keccak_slice_pkg: shared slice geometry, FSM states and column-parity helper for the slice-serial Keccak stages
package keccak_slice_pkg;
  localparam int SLICE_W    = 25;
  localparam int NUM_SLICES = 64;
  localparam int ADDR_W     = $clog2(NUM_SLICES);

  typedef enum logic [1:0] {IDLE, PARITY, EMIT, FIN} state_t;

  function automatic int bit_idx(input int x, input int y);
    return 5 * y + x;
  endfunction

  function automatic logic [4:0] col_parity(input logic [SLICE_W-1:0] s);
    logic [4:0] p;
    p = '0;
    for (int x = 0; x < 5; x++)
      for (int y = 0; y < 5; y++)
        p[x] = p[x] ^ s[bit_idx(x, y)];
    return p;
  endfunction
endpackage

// File: rtl/theta_slice_stage_if.sv
// theta_slice_stage_if: slice-memory read port, write stream and status of the theta stage
interface theta_slice_stage_if;
  import keccak_slice_pkg::*;
  logic               start;
  logic [ADDR_W-1:0]  rd_addr;
  logic [SLICE_W-1:0] line_in;
  logic               write_enable;
  logic [SLICE_W-1:0] write_value;
  logic [ADDR_W-1:0]  wr_addr;
  logic               busy;
  logic               donee;
  modport slave  (input start, line_in, output rd_addr, write_enable, write_value, wr_addr, busy, donee);
  modport master (output start, line_in, input rd_addr, write_enable, write_value, wr_addr, busy, donee);
endinterface

// File: rtl/theta_column_mix.sv
// theta_column_mix: XORs the theta column effect into one slice from the parities of this slice and the previous one
module theta_column_mix
  import keccak_slice_pkg::*;
(
  input  logic [SLICE_W-1:0] i_slice,
  input  logic [4:0]         i_c_cur,
  input  logic [4:0]         i_c_prev,
  output logic [SLICE_W-1:0] o_slice
);
  for (genvar y = 0; y < 5; y++) begin : g_row
    for (genvar x = 0; x < 5; x++) begin : g_col
      assign o_slice[bit_idx(x, y)] = i_slice[bit_idx(x, y)] ^ i_c_cur[(x + 4) % 5] ^ i_c_prev[(x + 1) % 5];
    end
  end
endmodule

// File: rtl/theta_slice_stage.sv
// theta_slice_stage: two-pass slice-serial theta; pass 1 gathers column parities, pass 2 re-reads and emits mixed slices
module theta_slice_stage
  import keccak_slice_pkg::*;
(
  input logic                clk,
  input logic                rst,
  theta_slice_stage_if.slave bus
);
  state_t             r_state, w_next;
  logic [ADDR_W-1:0]  r_z;
  logic               r_ph;
  logic [4:0]         r_par [NUM_SLICES];
  logic [SLICE_W-1:0] r_wv, w_mix;
  logic [ADDR_W-1:0]  r_wa;
  logic               r_we, r_done, w_last;

  assign w_last = r_z == ADDR_W'(NUM_SLICES - 1);

  always_comb begin
    w_next = r_state == IDLE   ? (bus.start ? PARITY : IDLE) :
             r_state == PARITY ? (w_last ? EMIT : PARITY) :
             r_state == EMIT   ? (w_last && r_ph ? FIN : EMIT) : IDLE;
  end

  // slice z-1 wraps through the address width, so slice 0 pairs with slice 63
  theta_column_mix u_mix (
    .i_slice  (bus.line_in),
    .i_c_cur  (r_par[r_z]),
    .i_c_prev (r_par[r_z - ADDR_W'(1)]),
    .o_slice  (w_mix)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_z     <= '0;
      r_ph    <= 1'b0;
      r_we    <= 1'b0;
      r_wv    <= '0;
      r_wa    <= '0;
      r_done  <= 1'b0;
      for (int i = 0; i < NUM_SLICES; i++) r_par[i] <= '0;
    end else begin
      r_state <= w_next;
      r_done  <= r_state == FIN;
      r_we    <= r_state == EMIT && !r_ph;
      if (r_state == PARITY) begin
        r_par[r_z] <= col_parity(bus.line_in);
        r_z        <= r_z + ADDR_W'(1);
      end
      if (r_state == EMIT) begin
        r_ph <= !r_ph;
        if (r_ph) r_z <= r_z + ADDR_W'(1);
        else begin
          r_wv <= w_mix;
          r_wa <= r_z;
        end
      end
    end
  end

  assign bus.rd_addr      = r_z;
  assign bus.write_enable = r_we;
  assign bus.write_value  = r_wv;
  assign bus.wr_addr      = r_wa;
  assign bus.busy         = r_state == PARITY || r_state == EMIT;
  assign bus.donee        = r_done;
endmodule

// File: tb/tb_theta_slice_stage.sv
// tb_theta_slice_stage: directed-vector bench for the slice-serial theta stage with a behavioural slice memory
module tb_theta_slice_stage;
  import keccak_slice_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  theta_slice_stage_if bus();
  logic [SLICE_W-1:0] mem [NUM_SLICES];
  logic [SLICE_W-1:0] cap [NUM_SLICES];
  logic [SLICE_W-1:0] exp_s [NUM_SLICES];
  int checks = 0, passed = 0;
  int pulses, first_we, done_cyc, done_cnt, width_bad, order_bad, last_n;
  logic busy_at_start, busy_after;

  theta_slice_stage dut (.clk(clk), .rst(rst), .bus(bus.slave));

  assign bus.line_in = mem[bus.rd_addr];
  always #5 clk = ~clk;

  task automatic clear_mem();
    for (int i = 0; i < NUM_SLICES; i++) begin
      mem[i] = '0;
      exp_s[i] = '0;
    end
  endtask

  task automatic run_op(input bit hold, input int mid_at, input int abort_at);
    for (int i = 0; i < NUM_SLICES; i++) cap[i] = 'x;
    pulses = 0; first_we = -1; done_cyc = -1; done_cnt = 0;
    width_bad = 0; order_bad = 0; last_n = -1; busy_after = 1'bx;
    @(negedge clk); bus.start = 1'b1;
    @(posedge clk); #1;
    if (!hold) bus.start = 1'b0;
    busy_at_start = bus.busy;
    for (int n = 1; n <= 300; n++) begin
      @(posedge clk); #1;
      if (n == mid_at) bus.start = 1'b1;
      else if (n == mid_at + 1) bus.start = 1'b0;
      if (bus.write_enable) begin
        if (last_n >= 0 && n - last_n != 2) width_bad++;
        last_n = n;
        if (first_we < 0) first_we = n;
        if (bus.wr_addr !== ADDR_W'(pulses)) order_bad++;
        cap[bus.wr_addr] = bus.write_value;
        pulses++;
        if (abort_at >= 0 && int'(bus.wr_addr) == abort_at) return;
      end
      if (bus.donee) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = n;
      end
      if (done_cyc >= 0 && n == done_cyc + 1) busy_after = bus.busy;
      if (done_cyc >= 0 && n >= done_cyc + 2) break;
    end
  endtask

  task automatic test_reset();
    bus.start = 1'b0;
    clear_mem();
    repeat (2) @(posedge clk);
    #1;
    checks++; if (bus.rd_addr !== '0) $display("FAIL reset_rd_addr got %0d want 0", bus.rd_addr); else passed++;
    checks++; if (bus.wr_addr !== '0) $display("FAIL reset_wr_addr got %0d want 0", bus.wr_addr); else passed++;
    checks++; if (bus.write_enable !== 1'b0) $display("FAIL reset_we got %b want 0", bus.write_enable); else passed++;
    checks++; if (bus.write_value !== '0) $display("FAIL reset_wv got %h want 0", bus.write_value); else passed++;
    checks++; if (bus.busy !== 1'b0) $display("FAIL reset_busy got %b want 0", bus.busy); else passed++;
    checks++; if (bus.donee !== 1'b0) $display("FAIL reset_donee got %b want 0", bus.donee); else passed++;
    @(negedge clk); rst = 1'b1;
  endtask

  task automatic test_zero();
    clear_mem();
    run_op(1'b0, -1, -1);
    checks++; if (busy_at_start !== 1'b1) $display("FAIL zero_busy got %b want 1", busy_at_start); else passed++;
    checks++; if (pulses != 64) $display("FAIL zero_pulses got %0d want 64", pulses); else passed++;
    checks++; if (first_we != 65) $display("FAIL zero_first_we got %0d want 65", first_we); else passed++;
    checks++; if (done_cyc != 193) $display("FAIL zero_donee_cycle got %0d want 193", done_cyc); else passed++;
    checks++; if (done_cnt != 1) $display("FAIL zero_donee_width got %0d want 1", done_cnt); else passed++;
    checks++; if (width_bad != 0) $display("FAIL zero_we_spacing got %0d bad want 0", width_bad); else passed++;
    checks++; if (busy_after !== 1'b0) $display("FAIL zero_busy_after got %b want 0", busy_after); else passed++;
    for (int z = 0; z < NUM_SLICES; z++) begin
      checks++; if (cap[z] !== exp_s[z]) $display("FAIL zero_slice%0d got %h want %h", z, cap[z], exp_s[z]); else passed++;
    end
  endtask

  task automatic test_single();
    clear_mem();
    mem[0] = 25'h0000001;
    exp_s[0] = 25'h0210843;
    exp_s[1] = 25'h1084210;
    run_op(1'b0, -1, -1);
    checks++; if (pulses != 64) $display("FAIL single_pulses got %0d want 64", pulses); else passed++;
    for (int z = 0; z < NUM_SLICES; z++) begin
      checks++; if (cap[z] !== exp_s[z]) $display("FAIL single_slice%0d got %h want %h", z, cap[z], exp_s[z]); else passed++;
    end
  endtask

  task automatic test_wrap();
    clear_mem();
    mem[63] = 25'h0000001;
    exp_s[63] = 25'h0210843;
    exp_s[0] = 25'h1084210;
    run_op(1'b0, -1, -1);
    checks++; if (done_cyc != 193) $display("FAIL wrap_donee_cycle got %0d want 193", done_cyc); else passed++;
    for (int z = 0; z < NUM_SLICES; z++) begin
      checks++; if (cap[z] !== exp_s[z]) $display("FAIL wrap_slice%0d got %h want %h", z, cap[z], exp_s[z]); else passed++;
    end
  endtask

  task automatic test_cancel();
    clear_mem();
    mem[5] = 25'h0000021;
    exp_s[5] = 25'h0000021;
    run_op(1'b0, -1, -1);
    checks++; if (order_bad != 0) $display("FAIL cancel_wr_order got %0d bad want 0", order_bad); else passed++;
    checks++; if (pulses != 64) $display("FAIL cancel_pulses got %0d want 64", pulses); else passed++;
    for (int z = 0; z < NUM_SLICES; z++) begin
      checks++; if (cap[z] !== exp_s[z]) $display("FAIL cancel_slice%0d got %h want %h", z, cap[z], exp_s[z]); else passed++;
    end
  endtask

  task automatic test_mid_start();
    clear_mem();
    mem[0] = 25'h0000001;
    run_op(1'b0, 100, -1);
    checks++; if (pulses != 64) $display("FAIL midstart_pulses got %0d want 64", pulses); else passed++;
    checks++; if (width_bad != 0) $display("FAIL midstart_we_spacing got %0d bad want 0", width_bad); else passed++;
    checks++; if (done_cyc != 193) $display("FAIL midstart_donee_cycle got %0d want 193", done_cyc); else passed++;
    checks++; if (busy_after !== 1'b0) $display("FAIL midstart_retrigger got busy %b want 0", busy_after); else passed++;
    checks++; if (cap[0] !== 25'h0210843) $display("FAIL midstart_slice0 got %h want 0210843", cap[0]); else passed++;
    checks++; if (cap[1] !== 25'h1084210) $display("FAIL midstart_slice1 got %h want 1084210", cap[1]); else passed++;
  endtask

  task automatic test_back_to_back();
    bit seen;
    clear_mem();
    run_op(1'b1, -1, -1);
    checks++; if (done_cyc != 193) $display("FAIL b2b_donee_cycle got %0d want 193", done_cyc); else passed++;
    checks++; if (busy_after !== 1'b1) $display("FAIL b2b_retrigger got busy %b want 1", busy_after); else passed++;
    bus.start = 1'b0;
    seen = 1'b0;
    for (int n = 0; n < 300 && !seen; n++) begin
      @(posedge clk); #1;
      seen = bus.donee;
    end
    checks++; if (!seen) $display("FAIL b2b_drain got no donee want donee"); else passed++;
    @(posedge clk); #1;
  endtask

  task automatic test_abort();
    int stray;
    clear_mem();
    mem[0] = 25'h0000001;
    run_op(1'b0, -1, 30);
    checks++; if (pulses != 31) $display("FAIL abort_reach got %0d pulses want 31", pulses); else passed++;
    rst = 1'b0;
    #1;
    checks++; if (bus.write_enable !== 1'b0) $display("FAIL abort_we got %b want 0", bus.write_enable); else passed++;
    checks++; if (bus.write_value !== '0) $display("FAIL abort_wv got %h want 0", bus.write_value); else passed++;
    checks++; if (bus.wr_addr !== '0) $display("FAIL abort_wr_addr got %0d want 0", bus.wr_addr); else passed++;
    checks++; if (bus.rd_addr !== '0) $display("FAIL abort_rd_addr got %0d want 0", bus.rd_addr); else passed++;
    checks++; if (bus.busy !== 1'b0) $display("FAIL abort_busy got %b want 0", bus.busy); else passed++;
    checks++; if (bus.donee !== 1'b0) $display("FAIL abort_donee got %b want 0", bus.donee); else passed++;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    stray = 0;
    for (int n = 0; n < 200; n++) begin
      @(posedge clk); #1;
      if (bus.donee || bus.write_enable || bus.busy) stray++;
    end
    checks++; if (stray != 0) $display("FAIL abort_quiet got %0d active cycles want 0", stray); else passed++;
    exp_s[0] = 25'h0210843;
    exp_s[1] = 25'h1084210;
    run_op(1'b0, -1, -1);
    checks++; if (done_cyc != 193) $display("FAIL abort_rerun_donee got %0d want 193", done_cyc); else passed++;
    checks++; if (order_bad != 0) $display("FAIL abort_rerun_order got %0d bad want 0", order_bad); else passed++;
    for (int z = 0; z < NUM_SLICES; z++) begin
      checks++; if (cap[z] !== exp_s[z]) $display("FAIL abort_rerun_slice%0d got %h want %h", z, cap[z], exp_s[z]); else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_zero();
    test_single();
    test_wrap();
    test_cancel();
    test_mid_start();
    test_back_to_back();
    test_abort();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
